// File: rtl/valu_pkg.sv
// Shared types and constants for the pipelined vector ALU.
// Holds the opcode enum, flag bit positions and saturation limits.
package valu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SRA = 3'b111
    } valu_op_e;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Largest two's-complement value of a w-bit lane.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest two's-complement value of a w-bit lane.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/valu_if.sv
// Operand/result handshake bundle of the vector ALU.
// slave: the ALU side (takes operands, drives results); master: producer/consumer side.
interface valu_if
    import valu_pkg::*;
#(
    parameter int LANES = 3,
    parameter int WIDTH = 18
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] a;
    logic [LANES*WIDTH-1:0] b;
    valu_op_e               op;
    logic                   sat_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] result;
    logic [3:0]             flags;

    modport slave (
        input  in_valid, a, b, op, sat_en, out_ready,
        output in_ready, out_valid, result, flags
    );

    modport master (
        output in_valid, a, b, op, sat_en, out_ready,
        input  in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/valu_lane.sv
// Combinational single-lane compute: raw 2*WIDTH result, carry c, overflow v.
// Ports: a, b (lane operands), op (opcode) -> raw, c, v.
module valu_lane
    import valu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  valu_op_e           op,
    output logic [2*WIDTH-1:0] raw,
    output logic               c,
    output logic               v
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          uadd;
    logic [WIDTH:0]          usub;
    logic [WIDTH:0]          sadd;
    logic [WIDTH:0]          ssub;
    logic [2*WIDTH-1:0]      ax;
    logic [2*WIDTH-1:0]      bx;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH:0]          shl_ext;
    logic signed [WIDTH:0]   sra_ext;

    function automatic logic [2*WIDTH-1:0] sx(input logic [WIDTH-1:0] x);
        return {{WIDTH{x[WIDTH-1]}}, x};
    endfunction

    assign sh   = b[SHW-1:0];
    assign uadd = {1'b0, a} + {1'b0, b};
    assign usub = {1'b0, a} - {1'b0, b};
    assign sadd = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign ssub = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign ax   = sx(a);
    assign bx   = sx(b);
    // Low 2*WIDTH bits of sign-extended operands give the exact signed product.
    assign prod = ax * bx;
    // One extra bit on the far side of each shift catches the last bit shifted out;
    // oversized amounts naturally yield 0 (SHL) or the sign fill (SRA).
    assign shl_ext = {1'b0, a} << sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        raw = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                raw = {{(WIDTH-1){sadd[WIDTH]}}, sadd};
                c   = uadd[WIDTH];
                v   = sadd[WIDTH] ^ sadd[WIDTH-1];
            end
            OP_SUB: begin
                raw = {{(WIDTH-1){ssub[WIDTH]}}, ssub};
                c   = ~usub[WIDTH];
                v   = ssub[WIDTH] ^ ssub[WIDTH-1];
            end
            OP_MUL: begin
                raw = prod;
                v   = ~((&prod[2*WIDTH-1:WIDTH-1])
                      | ~(|prod[2*WIDTH-1:WIDTH-1]));
            end
            OP_AND: raw = sx(a & b);
            OP_OR:  raw = sx(a | b);
            OP_XOR: raw = sx(a ^ b);
            OP_SHL: begin
                raw = sx(shl_ext[WIDTH-1:0]);
                c   = shl_ext[WIDTH];
            end
            OP_SRA: begin
                raw = sx(sra_ext[WIDTH:1]);
                c   = sra_ext[0];
            end
        endcase
    end

endmodule

// File: rtl/valu_pipe.sv
// Two-stage vector ALU: stage 1 holds raw lane results, stage 2 the final vector.
// Ports: clk, reset (async, active-high), bus (valu_if.slave operand/result handshake).
module valu_pipe
    import valu_pkg::*;
#(
    parameter int LANES = 3,
    parameter int WIDTH = 18
) (
    input  logic   clk,
    input  logic   reset,
    valu_if.slave  bus
);

    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
    localparam logic signed [2*WIDTH-1:0] ZERO2 = '0;

    logic [2*WIDTH-1:0]     lane_raw [LANES];
    logic [LANES-1:0]       lane_c;
    logic [LANES-1:0]       lane_v;

    logic                   s1_valid;
    logic                   s1_sat;
    logic [2*WIDTH-1:0]     s1_raw [LANES];
    logic [LANES-1:0]       s1_c;
    logic [LANES-1:0]       s1_v;

    logic                   s2_valid;
    logic [LANES*WIDTH-1:0] s2_result;
    logic [3:0]             s2_flags;

    logic                   s2_can_load;
    logic                   in_fire;
    logic [WIDTH-1:0]       lane_q;
    logic [LANES*WIDTH-1:0] fin;
    logic [3:0]             fin_flags;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        valu_lane #(.WIDTH(WIDTH)) u_lane (
            .a   (bus.a[i*WIDTH +: WIDTH]),
            .b   (bus.b[i*WIDTH +: WIDTH]),
            .op  (bus.op),
            .raw (lane_raw[i]),
            .c   (lane_c[i]),
            .v   (lane_v[i])
        );
    end

    assign s2_can_load   = !s2_valid || bus.out_ready;
    assign bus.in_ready  = !s1_valid || s2_can_load;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.flags     = s2_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            s1_c     <= '0;
            s1_v     <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_raw[i] <= '0;
            end
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sat   <= bus.sat_en;
            s1_c     <= lane_c;
            s1_v     <= lane_v;
            for (int i = 0; i < LANES; i++) begin
                s1_raw[i] <= lane_raw[i];
            end
        end else if (s2_can_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Truncate, or clamp toward the sign of the true result on overflow.
    always_comb begin
        lane_q    = '0;
        fin       = '0;
        fin_flags = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_q = s1_raw[i][WIDTH-1:0];
            if (s1_sat && s1_v[i]) begin
                lane_q = ($signed(s1_raw[i]) < ZERO2) ? SMIN : SMAX;
            end
            fin[i*WIDTH +: WIDTH] = lane_q;
            fin_flags[FLAG_N] = fin_flags[FLAG_N] | lane_q[WIDTH-1];
        end
        fin_flags[FLAG_V] = |s1_v;
        fin_flags[FLAG_C] = |s1_c;
        fin_flags[FLAG_Z] = (fin == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_can_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= fin;
                s2_flags  <= fin_flags;
            end
        end
    end

endmodule

// File: tb/tb_valu_pipe.sv
// Self-checking bench for valu_pipe: arithmetic reference model plus directed literals.
// Drives the valu_if bundle; checks every meaningful output cycle against the model queue.
module tb_valu_pipe;
    import valu_pkg::*;

    localparam int LANES = 3;
    localparam int WIDTH = 18;

    typedef logic [LANES*WIDTH-1:0] vec_t;
    typedef struct packed {
        vec_t       r;
        logic [3:0] f;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t q[$];

    valu_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    valu_pipe #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t pk(input int l0, input int l1, input int l2);
        vec_t v;
        v[0*WIDTH +: WIDTH] = WIDTH'(l0);
        v[1*WIDTH +: WIDTH] = WIDTH'(l1);
        v[2*WIDTH +: WIDTH] = WIDTH'(l2);
        return v;
    endfunction

    // Reference: plain integer arithmetic on the true lane values.
    function automatic exp_t model(input vec_t av, input vec_t bv,
                                   input valu_op_e o, input logic s);
        exp_t   e;
        longint m, maxv, minv, ua, ub, sa, sb, t, res;
        int     sh;
        logic   c, v;
        m    = longint'(1) <<< WIDTH;
        maxv = m / 2 - 1;
        minv = -(m / 2);
        e    = '0;
        for (int i = 0; i < LANES; i++) begin
            ua = longint'(av[i*WIDTH +: WIDTH]);
            ub = longint'(bv[i*WIDTH +: WIDTH]);
            sa = (ua >= m / 2) ? ua - m : ua;
            sb = (ub >= m / 2) ? ub - m : ub;
            sh = int'(ub % 32);
            c  = 1'b0;
            v  = 1'b0;
            t  = 0;
            case (o)
                OP_ADD: begin t = sa + sb; c = (ua + ub) >= m; end
                OP_SUB: begin t = sa - sb; c = ua >= ub; end
                OP_MUL: t = sa * sb;
                OP_AND: t = sa & sb;
                OP_OR:  t = sa | sb;
                OP_XOR: t = sa ^ sb;
                OP_SHL: begin
                    t = (sh >= WIDTH) ? 0 : (ua << sh);
                    if (sh >= 1 && sh <= WIDTH)
                        c = ((ua >> (WIDTH - sh)) & 1) != 0;
                end
                default: begin
                    if (sh >= WIDTH) t = (sa < 0) ? -1 : 0;
                    else t = sa >>> sh;
                    if (sh == 0) c = 1'b0;
                    else if (sh <= WIDTH) c = ((sa >>> (sh - 1)) & 1) != 0;
                    else c = sa < 0;
                end
            endcase
            if (o inside {OP_ADD, OP_SUB, OP_MUL})
                v = (t > maxv) || (t < minv);
            res = (s && v) ? ((t > 0) ? maxv : minv) : t;
            e.r[i*WIDTH +: WIDTH] = WIDTH'(res);
            e.f[FLAG_V] = e.f[FLAG_V] | v;
            e.f[FLAG_C] = e.f[FLAG_C] | c;
            e.f[FLAG_N] = e.f[FLAG_N] | e.r[i*WIDTH + WIDTH - 1];
        end
        e.f[FLAG_Z] = (e.r == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every output-valid cycle against the model queue.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious output: got %0h expected none",
                             bus.result);
                end else begin
                    chk("model result", 64'(bus.result), 64'(q[0].r));
                    chk("model flags", 64'(bus.flags), 64'(q[0].f));
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.op, bus.sat_en));
        end
    end

    task automatic send(input vec_t av, input vec_t bv,
                        input valu_op_e o, input logic s);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.op       = o;
        bus.sat_en   = s;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input vec_t er,
                              input logic [3:0] ef);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        chk({name, " valid"}, 64'(bus.out_valid), 64'(1));
        chk({name, " latency"}, 64'(n), 64'(2));
        chk({name, " result"}, 64'(bus.result), 64'(er));
        chk({name, " flags"}, 64'(bus.flags), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input vec_t av, input vec_t bv,
                       input valu_op_e o, input logic s,
                       input vec_t er, input logic [3:0] ef);
        send(av, bv, o, s);
        bus.in_valid = 1'b0;
        expect_out(name, er, ef);
    endtask

    function automatic logic [WIDTH-1:0] rnd_lane();
        case ($urandom_range(0, 5))
            0: return 18'h1FFFF;
            1: return 18'h20000;
            2: return '0;
            3: return '1;
            4: return WIDTH'($urandom_range(0, 40));
            default: return WIDTH'($urandom());
        endcase
    endfunction

    initial begin
        exp_t e;
        int   sent;
        int   cyc;
        logic fired;
        checks        = 0;
        errors        = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        #12;
        chk("reset out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset result", 64'(bus.result), 64'(0));
        chk("reset flags", 64'(bus.flags), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Pin the reference model itself.
        e = model(pk(131071, 0, 0), pk(1, 0, 0), OP_ADD, 1'b1);
        chk("pin add sat r", 64'(e.r), 64'(pk(131071, 0, 0)));
        chk("pin add sat f", 64'(e.f), 64'(4'b1000));
        e = model(pk(-8, 7, -1), pk(2, 1, 17), OP_SRA, 1'b0);
        chk("pin sra r", 64'(e.r), 64'(pk(-2, 3, -1)));
        e = model(pk(1, 0, -2), pk(18, 0, 18), OP_SHL, 1'b0);
        chk("pin shl18 f", 64'(e.f), 64'(4'b0110));

        run("add", pk(4, 8, 5), pk(4, 2, 10), OP_ADD, 1'b0,
            pk(8, 10, 15), 4'b0000);
        run("sub", pk(2010, 300, 350), pk(-10, 300, -400), OP_SUB, 1'b0,
            pk(2020, 0, 750), 4'b0100);
        run("add sat", pk(131071, 0, 0), pk(1, 0, 0), OP_ADD, 1'b1,
            pk(131071, 0, 0), 4'b1000);
        run("add wrap", pk(131071, 0, 0), pk(1, 0, 0), OP_ADD, 1'b0,
            pk(-131072, 0, 0), 4'b1001);
        run("mul sat", pk(1000, -5, 2), pk(1000, 7, 0), OP_MUL, 1'b1,
            pk(131071, -35, 0), 4'b1001);
        run("shl", pk(1, 'h20000, 3), pk(4, 1, 20), OP_SHL, 1'b0,
            pk(16, 0, 0), 4'b0100);
        run("sra", pk(-8, 7, -1), pk(2, 1, 17), OP_SRA, 1'b0,
            pk(-2, 3, -1), 4'b0101);
        run("and", pk('h3F0F0, 5, -1), pk('h0FFFF, 3, 0), OP_AND, 1'b0,
            pk('h0F0F0, 1, 0), 4'b0000);
        run("sra edge", pk(-2, 5, 6), pk(18, 0, 31), OP_SRA, 1'b0,
            pk(-1, 5, 0), 4'b0101);
        run("sub sat", pk(-131072, 0, 5), pk(1, 0, 5), OP_SUB, 1'b1,
            pk(-131072, 0, 0), 4'b1101);

        // Backpressure: two vectors fill the pipe, the third waits.
        bus.out_ready = 1'b0;
        send(pk(1, 2, 3), pk(10, 20, 30), OP_ADD, 1'b0);
        send(pk(5, 5, 5), pk(1, 2, 3), OP_SUB, 1'b0);
        bus.a  = pk(1, 2, 4);
        bus.b  = pk(2, 4, 8);
        bus.op = OP_OR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall in_ready", 64'(bus.in_ready), 64'(0));
            chk("stall hold", 64'(bus.result), 64'(pk(11, 22, 33)));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("drain in_ready", 64'(bus.in_ready), 64'(1));
        chk("drain v1", 64'(bus.result), 64'(pk(11, 22, 33)));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drain v2 valid", 64'(bus.out_valid), 64'(1));
        chk("drain v2", 64'(bus.result), 64'(pk(4, 3, 2)));
        @(negedge clk);
        chk("drain v3 valid", 64'(bus.out_valid), 64'(1));
        chk("drain v3", 64'(bus.result), 64'(pk(3, 6, 12)));
        @(negedge clk);
        chk("drain done", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        send(pk(7, 7, 7), pk(1, 1, 1), OP_ADD, 1'b0);
        send(pk(9, 9, 9), pk(1, 1, 1), OP_XOR, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full in_ready", 64'(bus.in_ready), 64'(0));
        chk("full out_valid", 64'(bus.out_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("async out_valid", 64'(bus.out_valid), 64'(0));
        chk("async result", 64'(bus.result), 64'(0));
        chk("async flags", 64'(bus.flags), 64'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("rst in_ready", 64'(bus.in_ready), 64'(1));
            chk("no stale", 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Mixed stream with random consumer stalls, checked by the model.
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || bus.in_valid) && cyc < 600) begin
            if (!bus.in_valid && sent < 40) begin
                bus.a = {rnd_lane(), rnd_lane(), rnd_lane()};
                bus.b = {rnd_lane(), rnd_lane(), rnd_lane()};
                bus.op = valu_op_e'($urandom_range(0, 7));
                bus.sat_en = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
                sent++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (fired) bus.in_valid = 1'b0;
            cyc++;
        end
        chk("stream done", 64'(sent == 40 && !bus.in_valid), 64'(1));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("queue empty", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
